i2c_master_byte: RTL and testbench

Single-byte I2C master that generates SCL and drives/samples SDA (open-drain) to feed the I2C slave receiver on the same bus. Accepts one command (7-bit address, R/W, write byte) and sequences START, address+R/W, ACK check, one data byte, ACK/NACK, STOP. Sits between the system-side controller and the bus pins; the slave receiver is its direct downstream consumer.

---
 rtl/i2c_master_byte_pkg.sv | 31 +++
 rtl/i2c_qtick_gen.sv | 34 +++
 rtl/i2c_master_byte.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_master_byte.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_byte_pkg.sv
// Shared encodings for the single-byte I2C master: FSM states, quarter phases,
// and bit-counter sizing.
package i2c_master_byte_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_ADDR     = 4'd2,
        ST_ADDR_ACK = 4'd3,
        ST_WR_DATA  = 4'd4,
        ST_WR_ACK   = 4'd5,
        ST_RD_DATA  = 4'd6,
        ST_RD_NACK  = 4'd7,
        ST_STOP     = 4'd8
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int BIT_CNT_W = 3;
    localparam logic [BIT_CNT_W-1:0] BIT_FIRST = 3'd7;
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = 3'd0;

    // States that shift a byte out or in, one bit per SCL period.
    function automatic logic is_byte_state(state_t s);
        return (s == ST_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// SCL quarter-period tick: counts 0..DIVIDE_BY-1 while enabled, pulses on the
// terminal count and wraps.
module i2c_qtick_gen #(
    parameter int DIVIDE_BY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIVIDE_BY > 1) ? $clog2(DIVIDE_BY) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVIDE_BY - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// SCL is push-pull; SDA is open-drain via sda_oe. All outputs are registered.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | bus released, waiting for start
//   START    | SDA falls while SCL high during q2-q3
//   ADDR     | 8 bits {addr, rw}, MSB first
//   ADDR_ACK | SDA released, slave ACK sampled at q3
//   WR_DATA  | 8 bits of captured data_wr, MSB first
//   WR_ACK   | SDA released, slave ACK sampled at q3
//   RD_DATA  | SDA released, 8 bits sampled into the shift register
//   RD_NACK  | SDA released (NACK), received byte published at the end
//   STOP     | SDA rises while SCL high during q2-q3, then back to IDLE
module i2c_master_byte
    import i2c_master_byte_pkg::*;
#(
    parameter int DIVIDE_BY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_wr,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda_oe,
    output logic [7:0] data_rd,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    state_t state, state_nxt;

    logic                 tick;
    logic                 bit_end;
    logic                 accept;
    logic [1:0]           qphase;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           shreg;
    logic [7:0]           wr_q;
    logic                 rw_q;
    logic                 ack_pend;
    logic                 scl_c;
    logic                 sda_oe_c;

    logic       scl_q;
    logic       sda_oe_q;
    logic       busy_q;
    logic       done_q;
    logic       ack_err_q;
    logic [7:0] data_rd_q;

    i2c_qtick_gen #(
        .DIVIDE_BY (DIVIDE_BY)
    ) u_qtick (
        .clk   (clk),
        .reset (reset),
        .en    (state != ST_IDLE),
        .clr   (state == ST_IDLE),
        .tick  (tick)
    );

    assign bit_end = tick && (qphase == Q3);

    // busy_q/done_q lag the state by one cycle, so gating on them keeps a start
    // held through the done cycle from being taken until the cycle after it.
    assign accept = (state == ST_IDLE) && start && !busy_q && !done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scl_c     = 1'b1;
        sda_oe_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                sda_oe_c = qphase[1];
                if (bit_end) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                scl_c    = qphase[1];
                sda_oe_c = ~shreg[7];
                if (bit_end && (bit_cnt == BIT_LAST)) begin
                    state_nxt = ST_ADDR_ACK;
                end
            end
            ST_ADDR_ACK: begin
                scl_c = qphase[1];
                if (bit_end) begin
                    if (sda_in) begin
                        state_nxt = ST_STOP;
                    end else if (rw_q) begin
                        state_nxt = ST_RD_DATA;
                    end else begin
                        state_nxt = ST_WR_DATA;
                    end
                end
            end
            ST_WR_DATA: begin
                scl_c    = qphase[1];
                sda_oe_c = ~shreg[7];
                if (bit_end && (bit_cnt == BIT_LAST)) begin
                    state_nxt = ST_WR_ACK;
                end
            end
            ST_WR_ACK: begin
                scl_c = qphase[1];
                if (bit_end) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_RD_DATA: begin
                scl_c = qphase[1];
                if (bit_end && (bit_cnt == BIT_LAST)) begin
                    state_nxt = ST_RD_NACK;
                end
            end
            ST_RD_NACK: begin
                scl_c = qphase[1];
                if (bit_end) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                scl_c    = (qphase != Q0);
                sda_oe_c = ~qphase[1];
                if (bit_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qphase    <= Q0;
            bit_cnt   <= '0;
            shreg     <= '0;
            wr_q      <= '0;
            rw_q      <= 1'b0;
            ack_pend  <= 1'b0;
            data_rd_q <= '0;
        end else begin
            if (state == ST_IDLE) begin
                qphase <= Q0;
            end else if (tick) begin
                qphase <= qphase + 2'd1;
            end

            if (accept) begin
                shreg    <= {addr, rw};
                wr_q     <= data_wr;
                rw_q     <= rw;
                ack_pend <= 1'b0;
            end else if (bit_end) begin
                // Shifting at the end of each bit presents the next bit on
                // shreg[7] in time for the following q0 (SCL low).
                if (is_byte_state(state)) begin
                    bit_cnt <= bit_cnt - BIT_CNT_W'(1);
                end
                case (state)
                    ST_START: begin
                        bit_cnt <= BIT_FIRST;
                    end
                    ST_ADDR, ST_WR_DATA: begin
                        shreg <= {shreg[6:0], 1'b0};
                    end
                    ST_ADDR_ACK: begin
                        if (sda_in) begin
                            ack_pend <= 1'b1;
                        end else begin
                            bit_cnt <= BIT_FIRST;
                            if (!rw_q) begin
                                shreg <= wr_q;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (sda_in) begin
                            ack_pend <= 1'b1;
                        end
                    end
                    ST_RD_DATA: begin
                        shreg <= {shreg[6:0], sda_in};
                    end
                    ST_RD_NACK: begin
                        data_rd_q <= shreg;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Output stage: busy follows the state one cycle later, and done fires on
    // the first cycle the state is back in IDLE while busy is still high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            scl_q    <= scl_c;
            sda_oe_q <= sda_oe_c;
            busy_q   <= (state != ST_IDLE);
            done_q   <= (state == ST_IDLE) && busy_q;
            if ((state == ST_IDLE) && busy_q) begin
                ack_err_q <= ack_pend;
            end
        end
    end

    assign scl     = scl_q;
    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign data_rd = data_rd_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: table of single transfers against a slave model
// on a DIVIDE_BY=4 instance, plus reset and held-start sequences at DIVIDE_BY=1.
module tb_i2c_master_byte;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // DIVIDE_BY = 4 instance with slave model
    logic       start = 1'b0;
    logic [6:0] addr = '0;
    logic       rw = 1'b0;
    logic [7:0] data_wr = '0;
    logic       sda_in;
    logic       scl, sda_oe, busy, done, ack_err;
    logic [7:0] data_rd;

    // DIVIDE_BY = 1 instance, no slave on its bus (every address NACKs)
    logic       start1 = 1'b0;
    logic [6:0] addr1 = '0;
    logic       rw1 = 1'b0;
    logic [7:0] data_wr1 = '0;
    logic       sda_in1;
    logic       scl1, sda_oe1, busy1, done1, ack_err1;
    logic [7:0] data_rd1;

    logic pull = 1'b0;
    assign sda_in  = ~(sda_oe | pull);
    assign sda_in1 = ~sda_oe1;

    i2c_master_byte #(.DIVIDE_BY(4)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .rw(rw),
        .data_wr(data_wr), .sda_in(sda_in), .scl(scl), .sda_oe(sda_oe),
        .data_rd(data_rd), .busy(busy), .done(done), .ack_err(ack_err)
    );

    i2c_master_byte #(.DIVIDE_BY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .addr(addr1), .rw(rw1),
        .data_wr(data_wr1), .sda_in(sda_in1), .scl(scl1), .sda_oe(sda_oe1),
        .data_rd(data_rd1), .busy(busy1), .done(done1), .ack_err(ack_err1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model and bus monitor for dut. Any SDA change while SCL stays high
    // is counted as START (falling SDA) or STOP (rising SDA).
    logic       slv_ack_addr = 1'b0, slv_ack_data = 1'b0;
    logic [7:0] slv_rd = '0;
    logic [7:0] sl_addr = '0, sl_wr = '0;
    logic       mst_nack_oe = 1'b1;
    logic       p_scl = 1'b1, p_oe = 1'b0;
    int         rise_cnt = 0, nxt = 0;
    int         start_ev = 0, stop_ev = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            pull  = 1'b0;
            p_scl = 1'b1;
            p_oe  = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (p_scl && scl && (sda_oe != p_oe)) begin
                if (sda_oe) begin
                    start_ev++;
                    rise_cnt = 0;
                    pull = 1'b0;
                end else begin
                    stop_ev++;
                end
            end
            if (!p_scl && scl) begin
                rise_cnt++;
                if (rise_cnt <= 8)
                    sl_addr = {sl_addr[6:0], ~sda_oe};
                else if (rise_cnt >= 10 && rise_cnt <= 17)
                    sl_wr = {sl_wr[6:0], ~sda_oe};
                else if (rise_cnt == 18)
                    mst_nack_oe = sda_oe;
            end
            if (p_scl && !scl) begin
                nxt  = rise_cnt + 1;
                pull = 1'b0;
                if (slv_ack_addr) begin
                    if (nxt == 9)
                        pull = 1'b1;
                    else if (sl_addr[0] && nxt >= 10 && nxt <= 17)
                        pull = ~slv_rd[17 - nxt];
                    else if (!sl_addr[0] && nxt == 18 && slv_ack_data)
                        pull = 1'b1;
                end
            end
            p_scl = scl;
            p_oe  = sda_oe;
        end
    end

    logic p_scl1 = 1'b1, p_oe1 = 1'b0;
    int   start1_ev = 0, stop1_ev = 0, done1_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            p_scl1 = 1'b1;
            p_oe1  = 1'b0;
        end else begin
            if (done1) done1_cnt++;
            if (p_scl1 && scl1 && (sda_oe1 != p_oe1)) begin
                if (sda_oe1) start1_ev++;
                else stop1_ev++;
            end
            p_scl1 = scl1;
            p_oe1  = sda_oe1;
        end
    end

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wr;
        logic       ack_a;
        logic       ack_d;
        logic [7:0] rd;
        logic [7:0] e_abyte;
        logic       chk_wr;
        int         e_cyc;
        int         e_rises;
        logic       e_err;
        logic [7:0] e_rd;
    } vec_t;

    vec_t vecs[5];

    int cyc, lows, s0, p0, d0;

    initial begin
        //           addr   rw  wr     ackA ackD rd      abyte  chkwr cyc  rises err  data_rd
        vecs[0] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 8'hA0, 1'b1, 321, 19, 1'b0, 8'h00};
        vecs[1] = '{7'h3C, 1'b1, 8'h00, 1'b1, 1'b1, 8'h96, 8'h79, 1'b0, 321, 19, 1'b0, 8'h96};
        vecs[2] = '{7'h11, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h22, 1'b0, 177, 10, 1'b1, 8'h96};
        vecs[3] = '{7'h22, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h44, 1'b1, 321, 19, 1'b1, 8'h96};
        vecs[4] = '{7'h7F, 1'b1, 8'hC3, 1'b1, 1'b1, 8'h01, 8'hFF, 1'b0, 321, 19, 1'b0, 8'h01};

        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", scl, 1);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_data_rd", data_rd, 8'h00);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            addr         = vecs[i].addr;
            rw           = vecs[i].rw;
            data_wr      = vecs[i].wr;
            slv_ack_addr = vecs[i].ack_a;
            slv_ack_data = vecs[i].ack_d;
            slv_rd       = vecs[i].rd;
            s0 = start_ev;
            p0 = stop_ev;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            addr = 7'h00;
            data_wr = 8'h00;
            check($sformatf("v%0d_busy_latency", i), busy, 0);
            cyc = 0;
            while (cyc < 2000) begin
                @(posedge clk);
                #1;
                cyc++;
                if (cyc == 1) check($sformatf("v%0d_busy_rise", i), busy, 1);
                if (done) break;
            end
            check($sformatf("v%0d_done_cycle", i), cyc, vecs[i].e_cyc);
            check($sformatf("v%0d_busy_at_done", i), busy, 0);
            check($sformatf("v%0d_ack_err", i), ack_err, vecs[i].e_err);
            check($sformatf("v%0d_data_rd", i), data_rd, vecs[i].e_rd);
            check($sformatf("v%0d_addr_byte", i), sl_addr, vecs[i].e_abyte);
            if (vecs[i].chk_wr) check($sformatf("v%0d_wr_byte", i), sl_wr, vecs[i].wr);
            if (vecs[i].rw) check($sformatf("v%0d_master_nack", i), mst_nack_oe, 0);
            check($sformatf("v%0d_scl_rises", i), rise_cnt, vecs[i].e_rises);
            check($sformatf("v%0d_start_events", i), start_ev - s0, 1);
            check($sformatf("v%0d_stop_events", i), stop_ev - p0, 1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), done, 0);
            repeat (5) @(posedge clk);
            #1;
        end

        // Reset partway through the address byte
        addr = 7'h50;
        rw = 1'b0;
        data_wr = 8'hA5;
        slv_ack_addr = 1'b1;
        slv_ack_data = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid_addr_busy", busy, 1);
        d0 = done_cnt;
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_scl", scl, 1);
        check("mid_rst_sda_oe", sda_oe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_data_rd", data_rd, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_idle", busy, 0);

        // DIVIDE_BY=1, start held high across the done cycle
        addr1 = 7'h0A;
        rw1 = 1'b0;
        data_wr1 = 8'h5A;
        s0 = start1_ev;
        p0 = stop1_ev;
        d0 = done1_cnt;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        while (cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done1) break;
        end
        check("d1_first_done_cycle", cyc, 45);
        check("d1_busy_at_done", busy1, 0);
        lows = 1;
        while (lows < 20) begin
            @(posedge clk);
            #1;
            if (busy1) break;
            lows++;
        end
        check("d1_busy_low_gap", lows, 3);
        start1 = 1'b0;
        cyc = 0;
        while (cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done1) break;
        end
        check("d1_second_done_cycle", cyc, 44);
        repeat (60) @(posedge clk);
        #1;
        check("d1_done_count", done1_cnt - d0, 2);
        check("d1_idle", busy1, 0);
        check("d1_ack_err", ack_err1, 1);
        check("d1_start_events", start1_ev - s0, 2);
        check("d1_stop_events", stop1_ev - p0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
